ehl_tap_udr: RTL and testbench

User test-data-register bank that sits directly downstream of the IEEE 1149.1 TAP controller. It consumes the TAP's `instruction`, `capture_dr`, `shift_dr`, `update_dr` and `reset_state` strobes, and returns the serial `tdr_in` bit that the TAP drives onto TDO. It provides TDR_CNT user registers, each DR_WIDTH bits wide, with parallel capture inputs, parallel update outputs and per-register update strobes. It also checks the shift length, so a Update-DR after a truncated or overlong scan does not corrupt the outputs.

---
 rtl/ehl_tap_pkg.sv | 17 +
 rtl/ehl_tap_udr.sv | 88 ++++++++
 tb/tb_ehl_tap_udr.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ehl_tap_pkg.sv
// ehl_tap_pkg: shared TAP constants, state encodings and helpers
package ehl_tap_pkg;
  localparam int IR_IDCODE = 1;
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR,
    UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int ir_bypass(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/ehl_tap_udr.sv
// ehl_tap_udr: user TDR bank behind an 1149.1 TAP with shift-length checking
module ehl_tap_udr
  import ehl_tap_pkg::*;
#(
  parameter int IR_WIDTH = 4,
  parameter int DR_WIDTH = 8,
  parameter int TDR_CNT  = 2,
  parameter int TDR_BASE = 4
) (
  input  logic                        tck,
  input  logic                        trst_n,
  input  logic                        tdi,
  input  logic [IR_WIDTH-1:0]         instruction,
  input  logic                        capture_dr,
  input  logic                        shift_dr,
  input  logic                        update_dr,
  input  logic                        reset_state,
  input  logic [TDR_CNT*DR_WIDTH-1:0] cpt_data,
  output logic                        tdr_in,
  output logic [TDR_CNT*DR_WIDTH-1:0] upd_data,
  output logic [TDR_CNT-1:0]          upd_stb,
  output logic                        len_err
);
  localparam int CW = clog2(DR_WIDTH + 2);
  if (DR_WIDTH < 2 || TDR_CNT < 1 ||
      (TDR_BASE <= IR_IDCODE && TDR_BASE + TDR_CNT - 1 >= IR_IDCODE) ||
      TDR_BASE + TDR_CNT - 1 >= ir_bypass(IR_WIDTH)) begin : g_bad_cfg
    $fatal(1, "ehl_tap_udr: TDR range overlaps BYPASS/IDCODE or bad sizes");
  end
  logic [TDR_CNT-1:0]  hit;
  logic                sel_hit;
  logic                len_ok;
  logic [DR_WIDTH-1:0] cap_val;
  logic [DR_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_d;
  for (genvar k = 0; k < TDR_CNT; k++) begin : g_hit
    assign hit[k] = instruction == IR_WIDTH'(TDR_BASE + k);
  end
  assign sel_hit = |hit;
  assign tdr_in  = sel_hit & shreg_q[0];
  assign len_ok  = cnt_q == CW'(DR_WIDTH);
  always_comb begin
    cap_val = '0;
    for (int i = 0; i < TDR_CNT; i++)
      cap_val = cap_val | (hit[i] ? cpt_data[i*DR_WIDTH +: DR_WIDTH] : '0);
  end
  always_comb begin
    shreg_d = !sel_hit ? shreg_q :
              capture_dr ? cap_val :
              shift_dr ? {tdi, shreg_q[DR_WIDTH-1:1]} : shreg_q;
    cnt_d   = !sel_hit ? cnt_q :
              capture_dr ? '0 :
              (shift_dr && cnt_q != CW'(DR_WIDTH + 1)) ? cnt_q + 1'b1 : cnt_q;
    err_d   = reset_state ? 1'b0 : (sel_hit && update_dr && !len_ok) ? 1'b1 : len_err;
  end
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end
  // update side runs on the falling edge so outputs settle mid Update-DR
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) len_err <= 1'b0;
    else         len_err <= err_d;
  end
  for (genvar k = 0; k < TDR_CNT; k++) begin : g_bank
    logic [DR_WIDTH-1:0] upd_q, upd_d;
    logic                stb_q, fire;
    assign fire  = hit[k] && update_dr && len_ok && !reset_state;
    assign upd_d = reset_state ? '0 : fire ? shreg_q : upd_q;
    always_ff @(negedge tck or negedge trst_n) begin
      if (!trst_n) begin
        upd_q <= '0;
        stb_q <= 1'b0;
      end else begin
        upd_q <= upd_d;
        stb_q <= fire;
      end
    end
    assign upd_data[k*DR_WIDTH +: DR_WIDTH] = upd_q;
    assign upd_stb[k] = stb_q;
  end
endmodule

// File: tb/tb_ehl_tap_udr.sv
// tb_ehl_tap_udr: scoreboard bench for the user TDR bank
module tb_ehl_tap_udr;
  logic        tck = 1'b0;
  logic        trst_n, tdi, capture_dr, shift_dr, update_dr, reset_state;
  logic [3:0]  instruction;
  logic [15:0] cpt_data;
  logic        tdr_in;
  logic [15:0] upd_data;
  logic [1:0]  upd_stb;
  logic        len_err;
  int          checks = 0;
  int          errors = 0;
  logic        exp_q[$];
  logic        obs_q[$];
  logic [7:0]  m_sh;
  int          m_cnt;
  logic [15:0] m_upd;
  logic [1:0]  m_stb;
  logic        m_err;

  always #5 tck = ~tck;

  ehl_tap_udr dut (
    .tck(tck), .trst_n(trst_n), .tdi(tdi), .instruction(instruction),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .reset_state(reset_state), .cpt_data(cpt_data), .tdr_in(tdr_in),
    .upd_data(upd_data), .upd_stb(upd_stb), .len_err(len_err)
  );

  function automatic bit m_sel();
    return instruction == 4'h4 || instruction == 4'h5;
  endfunction

  function automatic int m_idx();
    return int'(instruction) - 4;
  endfunction

  task automatic cyc(input logic c, input logic s, input logic u, input logic r, input logic d);
    capture_dr = c; shift_dr = s; update_dr = u; reset_state = r; tdi = d;
    @(negedge tck); #1;
    if (s) obs_q.push_back(tdr_in);
    @(posedge tck); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cap();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if (m_sel()) begin
      m_sh  = cpt_data[m_idx()*8 +: 8];
      m_cnt = 0;
    end
  endtask

  task automatic shift(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(m_sel() ? m_sh[0] : 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, d[i]);
      if (m_sel()) begin
        m_sh = {d[i], m_sh[7:1]};
        if (m_cnt < 9) m_cnt++;
      end
    end
  endtask

  task automatic upd();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    m_stb = 2'b00;
    if (m_sel()) begin
      if (m_cnt == 8) begin
        m_upd[m_idx()*8 +: 8] = m_sh;
        m_stb[m_idx()] = 1'b1;
      end else m_err = 1'b1;
    end
  endtask

  task automatic test_reset();
    trst_n = 1'b0; tdi = 0; capture_dr = 0; shift_dr = 0; update_dr = 0; reset_state = 0;
    instruction = 4'h4; cpt_data = '0;
    m_sh = '0; m_cnt = 0; m_upd = '0; m_stb = '0; m_err = 1'b0;
    #12;
    checks++; if (tdr_in !== 1'b0) begin errors++; $display("FAIL rst_tdr_in got %b want 0", tdr_in); end
    checks++; if (upd_data !== 16'h0) begin errors++; $display("FAIL rst_upd_data got %h want 0000", upd_data); end
    checks++; if (upd_stb !== 2'b00) begin errors++; $display("FAIL rst_upd_stb got %b want 00", upd_stb); end
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL rst_len_err got %b want 0", len_err); end
    @(posedge tck); #1;
    trst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_capture();
    logic e, o;
    instruction = 4'h4; cpt_data = 16'h5AA5;
    idle(1);
    cap();
    shift(16'h0000, 8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 1'bx;
      checks++; if (o !== e) begin errors++; $display("FAIL capture_tdo got %b want %b", o, e); end
    end
    idle(1);
  endtask

  task automatic test_update();
    logic e, o;
    instruction = 4'h5;
    idle(1);
    cap();
    shift(16'h003C, 8);
    upd();
    checks++; if (upd_data !== m_upd) begin errors++; $display("FAIL upd_data got %h want %h", upd_data, m_upd); end
    checks++; if (upd_stb !== m_stb) begin errors++; $display("FAIL upd_stb_high got %b want %b", upd_stb, m_stb); end
    checks++; if (len_err !== m_err) begin errors++; $display("FAIL upd_len_err got %b want %b", len_err, m_err); end
    idle(1);
    checks++; if (upd_stb !== 2'b00) begin errors++; $display("FAIL upd_stb_low got %b want 00", upd_stb); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 1'bx;
      checks++; if (o !== e) begin errors++; $display("FAIL update_tdo got %b want %b", o, e); end
    end
  endtask

  task automatic test_pause();
    instruction = 4'h4;
    idle(1);
    cap();
    shift(16'h0081, 4);
    idle(3);
    shift(16'h0008, 4);
    upd();
    checks++; if (upd_data !== m_upd) begin errors++; $display("FAIL pause_upd_data got %h want %h", upd_data, m_upd); end
    checks++; if (upd_stb !== m_stb) begin errors++; $display("FAIL pause_upd_stb got %b want %b", upd_stb, m_stb); end
    checks++; if (len_err !== m_err) begin errors++; $display("FAIL pause_len_err got %b want %b", len_err, m_err); end
    exp_q.delete(); obs_q.delete();
    idle(1);
  endtask

  task automatic test_len_err();
    instruction = 4'h4;
    cap();
    shift(16'h007F, 7);
    upd();
    checks++; if (upd_data !== m_upd) begin errors++; $display("FAIL short_upd_data got %h want %h", upd_data, m_upd); end
    checks++; if (upd_stb !== m_stb) begin errors++; $display("FAIL short_upd_stb got %b want %b", upd_stb, m_stb); end
    checks++; if (len_err !== m_err) begin errors++; $display("FAIL short_len_err got %b want %b", len_err, m_err); end
    cap();
    shift(16'h01FF, 9);
    upd();
    checks++; if (upd_data !== m_upd) begin errors++; $display("FAIL long_upd_data got %h want %h", upd_data, m_upd); end
    checks++; if (len_err !== m_err) begin errors++; $display("FAIL long_len_err got %b want %b", len_err, m_err); end
    idle(4);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    m_upd = '0; m_err = 1'b0; m_stb = '0;
    checks++; if (len_err !== m_err) begin errors++; $display("FAIL tlr_len_err got %b want %b", len_err, m_err); end
    checks++; if (upd_data !== m_upd) begin errors++; $display("FAIL tlr_upd_data got %h want %h", upd_data, m_upd); end
    checks++; if (upd_stb !== m_stb) begin errors++; $display("FAIL tlr_upd_stb got %b want %b", upd_stb, m_stb); end
    exp_q.delete(); obs_q.delete();
    idle(1);
  endtask

  task automatic test_unselected();
    logic e, o;
    instruction = 4'hF; cpt_data = 16'hFFFF;
    idle(1);
    cap();
    shift(16'hFFFF, 8);
    upd();
    checks++; if (upd_stb !== 2'b00) begin errors++; $display("FAIL bypass_upd_stb got %b want 00", upd_stb); end
    checks++; if (upd_data !== m_upd) begin errors++; $display("FAIL bypass_upd_data got %h want %h", upd_data, m_upd); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 1'bx;
      checks++; if (o !== e) begin errors++; $display("FAIL bypass_tdo got %b want %b", o, e); end
    end
    idle(1);
  endtask

  task automatic test_trst();
    logic e, o;
    instruction = 4'h5; cpt_data = 16'h3800;
    idle(1);
    cap();
    shift(16'h00C3, 8);
    upd();
    checks++; if (upd_data !== m_upd) begin errors++; $display("FAIL pre_trst_upd_data got %h want %h", upd_data, m_upd); end
    idle(1);
    cap();
    shift(16'h0000, 3);
    checks++; if (tdr_in !== m_sh[0]) begin errors++; $display("FAIL pre_trst_tdo got %b want %b", tdr_in, m_sh[0]); end
    exp_q.delete(); obs_q.delete();
    #2 trst_n = 1'b0;
    m_sh = '0; m_cnt = 0; m_upd = '0; m_err = 1'b0; m_stb = '0;
    #1;
    checks++; if (upd_data !== m_upd) begin errors++; $display("FAIL trst_upd_data got %h want %h", upd_data, m_upd); end
    checks++; if (upd_stb !== m_stb) begin errors++; $display("FAIL trst_upd_stb got %b want %b", upd_stb, m_stb); end
    checks++; if (len_err !== m_err) begin errors++; $display("FAIL trst_len_err got %b want %b", len_err, m_err); end
    checks++; if (tdr_in !== 1'b0) begin errors++; $display("FAIL trst_tdo got %b want 0", tdr_in); end
    @(posedge tck); #1;
    trst_n = 1'b1;
    idle(1);
    cap();
    shift(16'h0096, 8);
    upd();
    checks++; if (upd_data !== m_upd) begin errors++; $display("FAIL post_trst_upd_data got %h want %h", upd_data, m_upd); end
    checks++; if (upd_stb !== m_stb) begin errors++; $display("FAIL post_trst_upd_stb got %b want %b", upd_stb, m_stb); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 1'bx;
      checks++; if (o !== e) begin errors++; $display("FAIL post_trst_tdo got %b want %b", o, e); end
    end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_capture();
    test_update();
    test_pause();
    test_len_err();
    test_unselected();
    test_trst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
